seg_scan_ctrl: RTL

- Time-multiplexed controller for a common-anode seven-segment display bank.
- Holds NUM_DIGITS 4-bit hex values and scans one digit per slot on a shared active-low segment bus, driving one active-low digit strobe at a time.
- Inserts a blanking gap before each digit to prevent ghosting.
- Accepts new display words over a valid/ready handshake, applied only at frame boundaries so a frame is never torn.

---
 rtl/seg_scan_pkg.sv | 18 +
 rtl/seg7_hex_dec.sv | 14 +
 rtl/seg_scan_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   // Active-high segment patterns {g,f,e,d,c,b,a}; entry n sits at bits [7n+6:7n].
   localparam logic [16*7-1:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex digit to active-high seven-segment pattern.
module seg7_hex_dec
   import seg_scan_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // Table lookup; glyphs for b and d are lower case to stay distinct from 8 and 0.
   always_comb begin
      seg = SEG_TABLE[int'(digit) * 7 +: 7];
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scanner with frame-aligned updates.
// Optional build macro SEG_SCAN_LEADING_ZERO_BLANK_EN: suppress digits above the
// most-significant nonzero digit (digit 0 always shown).
//
// state | meaning
// IDLE  | scan disabled, display dark, index/counter held at 0
// BLANK | first BLANK_CYC cycles of a slot, all strobes off
// SHOW  | remainder of the slot, strobe idx driven with its digit
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_DIV    = 50000,
   parameter int BLANK_CYC  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data,
   output logic                    ready,
   output logic [6:0]              seg_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_done
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int DW = 4 * NUM_DIGITS;
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] SHOW_START = CW'(BLANK_CYC);

   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DW-1:0]         active_q, active_d;
   logic [DW-1:0]         pending_q, pending_d;
   logic                  pend_v_q, pend_v_d;
   logic [6:0]            seg_n_q, seg_n_d;
   logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
   logic                  accept;
   logic                  suppress;
   logic [3:0]            digit_sel;
   logic [6:0]            seg_hi;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
   logic [IW-1:0]         msd;
`endif

   assign ready      = ~pend_v_q;
   assign frame_done = en && (state_q == SHOW) && (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);
   assign seg_n      = seg_n_q;
   assign an_n       = an_n_q;

   // Slot sequencing: the counter runs 0..CLK_DIV-1 per slot, BLANK below BLANK_CYC.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      if (!en) begin
         state_d = IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = BLANK;
               idx_d   = '0;
               cnt_d   = '0;
            end
            default: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                  state_d = BLANK;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = (cnt_d < SHOW_START) ? BLANK : SHOW;
               end
            end
         endcase
      end
   end

   // Display word handshake: new words only land in active at a frame boundary or while idle.
   always_comb begin
      active_d  = active_q;
      pending_d = pending_q;
      pend_v_d  = pend_v_q;
      accept    = load && !pend_v_q;
      if (state_q == IDLE && pend_v_q) begin
         active_d = pending_q;
         pend_v_d = 1'b0;
      end else if (frame_done) begin
         if (accept) begin
            active_d = data;
         end else if (pend_v_q) begin
            active_d = pending_q;
            pend_v_d = 1'b0;
         end
      end else if (accept) begin
         pending_d = data;
         pend_v_d  = 1'b1;
      end
   end

   assign digit_sel = active_d[{idx_d, 2'b00} +: 4];

   seg7_hex_dec u_dec (
      .digit (digit_sel),
      .seg   (seg_hi)
   );

   // Leading-zero suppression decision for the digit about to be shown.
   always_comb begin
      suppress = 1'b0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      msd = '0;
      for (int k = 1; k < NUM_DIGITS; k++) begin
         if (active_d[4*k +: 4] != 4'h0) msd = IW'(k);
      end
      suppress = (idx_d > msd);
`endif
   end

   // Output drive computed from next-state so strobes move on the same edge as the state.
   always_comb begin
      seg_n_d = SEG_OFF;
      an_n_d  = '1;
      if (state_d == SHOW && !suppress) begin
         an_n_d[idx_d] = 1'b0;
         seg_n_d       = ~seg_hi;
      end
   end

   // State, data and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= en ? BLANK : IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         active_q  <= '0;
         pending_q <= '0;
         pend_v_q  <= 1'b0;
         seg_n_q   <= SEG_OFF;
         an_n_q    <= '1;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         pend_v_q  <= pend_v_d;
         seg_n_q   <= seg_n_d;
         an_n_q    <= an_n_d;
      end
   end

endmodule
